// File: rtl/full_logic_nvc_if.sv
// Host-facing bundle for full_logic_nvc: threshold programming, push side,
// per-destination pop/read side and status. Clock and reset stay outside.
interface full_logic_nvc_if #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_D      = 2,
    parameter int TH_W       = 4
);
    logic                              init;
    logic [TH_W-1:0]                   umbral_MF;
    logic [TH_W-1:0]                   umbral_VC;
    logic [TH_W-1:0]                   umbral_D;
    logic                              push;
    logic [DATA_WIDTH-1:0]             data_in;
    logic [NUM_D-1:0]                  pop;
    logic [NUM_D-1:0][DATA_WIDTH-1:0]  data_out;
    logic [NUM_D-1:0]                  empty;
    logic [NUM_D-1:0]                  almost_empty;
    logic                              main_almost_full;
    logic                              idle_out;
    logic                              active_out;
    logic                              error_out;

    modport master (
        output init, umbral_MF, umbral_VC, umbral_D, push, data_in, pop,
        input  data_out, empty, almost_empty, main_almost_full,
               idle_out, active_out, error_out
    );

    modport slave (
        input  init, umbral_MF, umbral_VC, umbral_D, push, data_in, pop,
        output data_out, empty, almost_empty, main_almost_full,
               idle_out, active_out, error_out
    );
endinterface

// File: rtl/full_logic_nvc.sv
// Transaction-layer datapath: main FIFO -> per-VC FIFOs -> round-robin ->
// per-destination FIFOs, with threshold backpressure and a status FSM.

// Show-ahead FIFO; callers guarantee no write when full unless reading too.
module nvc_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;

    // Storage is not reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rp];
endmodule

module full_logic_nvc #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 2,
    parameter int NUM_D      = 2,
    parameter int MAIN_DEPTH = 4,
    parameter int VC_DEPTH   = 16,
    parameter int D_DEPTH    = 4,
    parameter int TH_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    full_logic_nvc_if.slave  bus
);
    localparam int DW  = $clog2(NUM_D);
    localparam int VW  = $clog2(NUM_VC);
    localparam int MAW = $clog2(MAIN_DEPTH);
    localparam int VAW = $clog2(VC_DEPTH);
    localparam int DAW = $clog2(D_DEPTH);

    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t state, state_n;
    logic [TH_W-1:0] th_mf, th_vc, th_d;
    logic [VW-1:0]   rr;

    logic [DATA_WIDTH-1:0]              m_head;
    logic [MAW:0]                       m_cnt;
    logic [VW-1:0]                      m_vc;
    logic                               mv, push_ok, push_drop, pop_err, run, xfer_en, any_cnt;
    logic [NUM_VC-1:0][DATA_WIDTH-1:0]  vc_head;
    logic [NUM_VC-1:0][VAW:0]           vc_cnt;
    logic [NUM_VC-1:0][DW-1:0]          vc_dst;
    logic [NUM_VC-1:0]                  vc_wr, vc_rd, vc_af, elig;
    logic [NUM_D-1:0][DATA_WIDTH-1:0]   d_head;
    logic [NUM_D-1:0][DAW:0]            d_cnt;
    logic [NUM_D-1:0]                   d_wr, d_rd, d_af;
    logic                               gnt_vld;
    logic [VW-1:0]                      gnt;

    assign run     = (state == S_IDLE) || (state == S_ACTIVE);
    assign xfer_en = (state != S_ERROR);

    // Main stage: head moves to its VC unless that VC is almost full.
    assign m_vc      = m_head[DATA_WIDTH-DW-1 -: VW];
    assign mv        = xfer_en && (m_cnt != '0) && !vc_af[m_vc];
    assign push_ok   = run && bus.push && ((32'(m_cnt) < MAIN_DEPTH) || mv);
    assign push_drop = run && bus.push && (32'(m_cnt) == MAIN_DEPTH) && !mv;
    assign pop_err   = run && |(bus.pop & bus.empty);

    assign bus.main_almost_full = (32'(m_cnt) + 32'(th_mf)) >= MAIN_DEPTH;

    nvc_fifo #(.W(DATA_WIDTH), .DEPTH(MAIN_DEPTH)) u_main (
        .clk(clk), .reset(reset), .wr(push_ok), .wdata(bus.data_in),
        .rd(mv), .rdata(m_head), .count(m_cnt)
    );

    genvar v, k;
    generate
        for (v = 0; v < NUM_VC; v++) begin : g_vc
            assign vc_dst[v] = vc_head[v][DATA_WIDTH-1 -: DW];
            assign vc_af[v]  = (32'(vc_cnt[v]) + 32'(th_vc)) >= VC_DEPTH;
            assign elig[v]   = xfer_en && (vc_cnt[v] != '0) && !d_af[vc_dst[v]];
            assign vc_wr[v]  = mv && (m_vc == VW'(v));
            assign vc_rd[v]  = gnt_vld && (gnt == VW'(v));
            nvc_fifo #(.W(DATA_WIDTH), .DEPTH(VC_DEPTH)) u_vc (
                .clk(clk), .reset(reset), .wr(vc_wr[v]), .wdata(m_head),
                .rd(vc_rd[v]), .rdata(vc_head[v]), .count(vc_cnt[v])
            );
        end

        for (k = 0; k < NUM_D; k++) begin : g_d
            assign d_af[k] = (32'(d_cnt[k]) + 32'(th_d)) >= D_DEPTH;
            assign d_wr[k] = gnt_vld && (vc_dst[gnt] == DW'(k));
            assign d_rd[k] = bus.pop[k] && (d_cnt[k] != '0);
            nvc_fifo #(.W(DATA_WIDTH), .DEPTH(D_DEPTH)) u_d (
                .clk(clk), .reset(reset), .wr(d_wr[k]), .wdata(vc_head[gnt]),
                .rd(d_rd[k]), .rdata(d_head[k]), .count(d_cnt[k])
            );
            assign bus.empty[k]        = (d_cnt[k] == '0);
            assign bus.data_out[k]     = bus.empty[k] ? '0 : d_head[k];
            // Held low in RESET so the post-reset output image is all zeros.
            assign bus.almost_empty[k] = (state != S_RESET) && (32'(d_cnt[k]) <= 32'(th_d));
        end
    endgenerate

    // Round-robin grant: first eligible VC after the last winner.
    always_comb begin
        logic [VW-1:0] idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = rr + VW'(i);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    // Any occupancy anywhere, from the registered counts.
    always_comb begin
        any_cnt = (m_cnt != '0);
        for (int i = 0; i < NUM_VC; i++) any_cnt |= (vc_cnt[i] != '0);
        for (int i = 0; i < NUM_D; i++)  any_cnt |= (d_cnt[i] != '0);
    end

    // Arbiter pointer and thresholds, latched continuously while in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr    <= VW'(NUM_VC - 1);
            th_mf <= '0;
            th_vc <= '0;
            th_d  <= '0;
        end else begin
            if (gnt_vld) rr <= gnt;
            if (state == S_INIT) begin
                th_mf <= bus.umbral_MF;
                th_vc <= bus.umbral_VC;
                th_d  <= bus.umbral_D;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_RESET;
        else       state <= state_n;
    end

    // Next state: errors win over init; ERROR is sticky until reset.
    always_comb begin
        state_n = state;
        case (state)
            S_RESET:  state_n = S_INIT;
            S_INIT:   state_n = bus.init ? S_INIT : S_IDLE;
            S_IDLE, S_ACTIVE: begin
                if (push_drop || pop_err) state_n = S_ERROR;
                else if (bus.init)        state_n = S_INIT;
                else if (any_cnt)         state_n = S_ACTIVE;
                else                      state_n = S_IDLE;
            end
            default:  state_n = S_ERROR;
        endcase
    end

    assign bus.idle_out   = (state == S_IDLE);
    assign bus.active_out = (state == S_ACTIVE);
    assign bus.error_out  = (state == S_ERROR);
endmodule

// File: tb/tb_full_logic_nvc.sv
// Randomized bench for full_logic_nvc against a queue-based reference model.
module tb_full_logic_nvc;
    localparam int DATA_WIDTH = 6, NUM_VC = 2, NUM_D = 2;
    localparam int MAIN_DEPTH = 4, VC_DEPTH = 16, D_DEPTH = 4, TH_W = 4;
    localparam int DW = $clog2(NUM_D), VW = $clog2(NUM_VC);
    localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;

    logic clk = 1'b0, reset;
    always #5 clk = ~clk;

    full_logic_nvc_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_D(NUM_D), .TH_W(TH_W)) bus ();

    full_logic_nvc #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_VC(NUM_VC), .NUM_D(NUM_D),
        .MAIN_DEPTH(MAIN_DEPTH), .VC_DEPTH(VC_DEPTH), .D_DEPTH(D_DEPTH), .TH_W(TH_W)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0, n_err = 0;
    int m_st = M_RST, rr = NUM_VC - 1, th_mf = 0, th_vc = 0, th_d = 0;
    logic [DATA_WIDTH-1:0] mq[$];
    logic [DATA_WIDTH-1:0] vq[NUM_VC][$];
    logic [DATA_WIDTH-1:0] dq[NUM_D][$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dst_of(input logic [DATA_WIDTH-1:0] w);
        return int'(w) / (1 << (DATA_WIDTH - DW));
    endfunction

    function automatic int vc_of(input logic [DATA_WIDTH-1:0] w);
        return (int'(w) / (1 << (DATA_WIDTH - DW - VW))) % NUM_VC;
    endfunction

    // One clock of the reference: all decisions from the pre-edge picture.
    task automatic model_step();
        bit run, frz, err, any, mv;
        int mvc, g, msz0;
        logic [DATA_WIDTH-1:0] gw;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < NUM_VC; i++) vq[i].delete();
            for (int i = 0; i < NUM_D; i++)  dq[i].delete();
            m_st = M_RST; rr = NUM_VC - 1; th_mf = 0; th_vc = 0; th_d = 0;
            return;
        end
        run = (m_st == M_IDLE) || (m_st == M_ACT);
        frz = (m_st == M_ERR);
        err = 0;
        any = mq.size() > 0;
        for (int i = 0; i < NUM_VC; i++) if (vq[i].size() > 0) any = 1;
        for (int i = 0; i < NUM_D; i++)  if (dq[i].size() > 0) any = 1;
        mv = 0; mvc = 0;
        if (!frz && mq.size() > 0) begin
            mvc = vc_of(mq[0]);
            mv  = (vq[mvc].size() + th_vc) < VC_DEPTH;
        end
        g = -1; gw = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            int c;
            c = (rr + i) % NUM_VC;
            if (g < 0 && !frz && vq[c].size() > 0 && (dq[dst_of(vq[c][0])].size() + th_d) < D_DEPTH) begin
                g = c; gw = vq[c][0];
            end
        end
        for (int i = 0; i < NUM_D; i++) begin
            if (bus.pop[i]) begin
                if (dq[i].size() > 0) void'(dq[i].pop_front());
                else if (run) err = 1;
            end
        end
        if (g >= 0) begin
            void'(vq[g].pop_front());
            dq[dst_of(gw)].push_back(gw);
            rr = g;
        end
        msz0 = mq.size();
        if (mv) vq[mvc].push_back(mq.pop_front());
        if (run && bus.push) begin
            if (msz0 < MAIN_DEPTH || mv) mq.push_back(bus.data_in);
            else err = 1;
        end
        case (m_st)
            M_RST:  m_st = M_INIT;
            M_INIT: begin
                th_mf = int'(bus.umbral_MF); th_vc = int'(bus.umbral_VC); th_d = int'(bus.umbral_D);
                m_st = bus.init ? M_INIT : M_IDLE;
            end
            M_IDLE, M_ACT: m_st = err ? M_ERR : bus.init ? M_INIT : any ? M_ACT : M_IDLE;
            default: m_st = M_ERR;
        endcase
    endtask

    task automatic compare_outputs();
        logic [NUM_D-1:0][DATA_WIDTH-1:0] e_do;
        logic [NUM_D-1:0] e_emp, e_ae;
        for (int i = 0; i < NUM_D; i++) begin
            e_emp[i] = dq[i].size() == 0;
            e_do[i]  = e_emp[i] ? '0 : dq[i][0];
            e_ae[i]  = (m_st != M_RST) && (dq[i].size() <= th_d);
        end
        chk("data_out", bus.data_out, e_do);
        chk("empty", bus.empty, e_emp);
        chk("almost_empty", bus.almost_empty, e_ae);
        chk("main_almost_full", bus.main_almost_full, (mq.size() + th_mf) >= MAIN_DEPTH);
        chk("status", {bus.idle_out, bus.active_out, bus.error_out},
            {m_st == M_IDLE, m_st == M_ACT, m_st == M_ERR});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic push_word(input logic [DATA_WIDTH-1:0] w);
        bus.push = 1'b1; bus.data_in = w; tick(); bus.push = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < NUM_D; i++) bus.pop[i] = dq[i].size() > 0;
            tick();
        end
        bus.pop = '0;
    endtask

    task automatic reset_init(input int mf, input int vc, input int d);
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        bus.init = 1'b1; bus.umbral_MF = TH_W'(mf); bus.umbral_VC = TH_W'(vc); bus.umbral_D = TH_W'(d);
        repeat (2) tick(); bus.init = 1'b0; repeat (2) tick();
    endtask

    logic [DATA_WIDTH-1:0] pat [3];

    initial begin
        pat[0] = 6'b000101; pat[1] = 6'b110110; pat[2] = 6'b001110;
        reset = 1'b1; bus.init = 1'b0; bus.push = 1'b0; bus.data_in = '0; bus.pop = '0;
        bus.umbral_MF = '0; bus.umbral_VC = '0; bus.umbral_D = '0;
        repeat (4) tick();
        chk("reset_status", {bus.idle_out, bus.active_out, bus.error_out}, 3'b000);
        chk("reset_empty", bus.empty, {NUM_D{1'b1}});

        // Init sequence, then single word through to dest0 and pop it.
        reset = 1'b0; bus.init = 1'b1;
        bus.umbral_MF = 4'd1; bus.umbral_VC = 4'd2; bus.umbral_D = 4'd2;
        repeat (2) tick(); bus.init = 1'b0; repeat (3) tick();
        chk("idle_after_init", bus.idle_out, 1'b1);
        push_word(6'b010000); repeat (2) tick();
        chk("dest0_latency", bus.empty[0], 1'b0);
        chk("dest0_word", bus.data_out[0], 6'b010000);
        bus.pop = 2'b01; tick(); bus.pop = '0; repeat (3) tick();

        // Two VCs into dest0, then a third word that must wait in its VC.
        push_word(6'b000011); push_word(6'b010100); push_word(6'b000111);
        repeat (8) tick();
        drain();

        // Well-behaved random traffic: no overflow, no empty pops.
        for (int c = 0; c < 250; c++) begin
            bus.push    = (mq.size() < MAIN_DEPTH) && ($urandom_range(0, 1) == 1);
            bus.data_in = DATA_WIDTH'($urandom);
            for (int i = 0; i < NUM_D; i++) bus.pop[i] = (dq[i].size() > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        bus.push = 1'b0; drain();

        // Overfill: head-of-line blocking fills main, then a dropped push.
        for (int i = 0; i < 39; i++) begin
            bus.push = 1'b1; bus.data_in = pat[i % 3]; tick();
        end
        bus.push = 1'b0; repeat (3) tick();
        chk("overflow_error", bus.error_out, 1'b1);
        bus.pop = 2'b11; repeat (12) tick(); bus.pop = '0;

        // Empty pop raises error; reset clears it.
        reset_init(1, 2, 2);
        bus.pop = 2'b10; tick(); bus.pop = '0;
        chk("pop_empty_error", bus.error_out, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("error_cleared", {bus.idle_out, bus.active_out, bus.error_out}, 3'b000);

        // Reset while words sit in every stage.
        bus.init = 1'b1; tick(); bus.init = 1'b0; repeat (2) tick();
        for (int i = 0; i < 8; i++) push_word(pat[i % 3]);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midreset_empty", bus.empty, {NUM_D{1'b1}});
        repeat (10) tick();
        chk("midreset_nothing", bus.empty, {NUM_D{1'b1}});

        // Unconstrained traffic with errors, re-inits and resets.
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.init = ($urandom_range(0, 49) == 0);
            if (bus.init) begin
                bus.umbral_MF = TH_W'($urandom_range(0, 4));
                bus.umbral_VC = TH_W'($urandom_range(0, 6));
                bus.umbral_D  = TH_W'($urandom_range(0, 3));
            end
            bus.push    = $urandom_range(0, 1) == 1;
            bus.data_in = DATA_WIDTH'($urandom);
            for (int i = 0; i < NUM_D; i++) bus.pop[i] = $urandom_range(0, 3) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
